bcd_conv_scheduler: RTL

- Shares one serial binary-to-BCD converter (double-dabble) between NCH sensor channels feeding the seven-segment display path.
- Converts on explicit per-channel requests and on a periodic refresh tick.
- Arbitrates pending channels round-robin.
- Holds the last converted 3-digit BCD result per channel in a stable output bank for the display driver.

---
 rtl/bcd_sched_pkg.sv | 41 ++++
 rtl/bcd_dd8_serial.sv | 69 ++++++
 rtl/bcd_conv_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bcd_sched_pkg.sv
// +----------------------------------------------------------------------+
// | bcd_sched_pkg : shared types, sizes and round-robin pick helper      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package bcd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam int unsigned BIN_W       = 8;
  localparam int unsigned BCD_W       = 12;
  localparam int unsigned SHIFT_STEPS = 8;

  // First set bit of pend at or after ptr, wrapping within nch channels.
  function automatic logic [2:0] rr_pick(input logic [7:0] pend,
                                         input logic [2:0] ptr,
                                         input int         nch);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = (int'(ptr) + i) % nch;
      if ((i < nch) && !found && pend[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_dd8_serial.sv
// +----------------------------------------------------------------------+
// | bcd_dd8_serial : 8-step serial double-dabble, 8-bit binary -> 3 BCD  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_dd8_serial
  import bcd_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_done
);

  logic [BIN_W-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [2:0]             step_q, step_d;
  logic                   run_q, run_d;
  logic [BCD_W-1:0]       w_adj;
  logic [BCD_W+BIN_W-1:0] w_shift;

  for (genvar n = 0; n < BCD_W / 4; n++) begin : g_nib
    assign w_adj[4*n +: 4] = (bcd_q[4*n +: 4] >= 4'd5) ? bcd_q[4*n +: 4] + 4'd3
                                                       : bcd_q[4*n +: 4];
  end

  // The top bit shifted out is always zero for 8-bit inputs.
  assign w_shift = {w_adj, bin_q} << 1;
  assign o_done  = run_q && (step_q == 3'(SHIFT_STEPS - 1));
  assign o_bcd   = bcd_q;

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    step_d = step_q;
    run_d  = run_q;
    if (i_start) begin
      bin_d  = i_bin;
      bcd_d  = '0;
      step_d = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      bcd_d  = w_shift[BCD_W+BIN_W-1:BIN_W];
      bin_d  = w_shift[BIN_W-1:0];
      step_d = step_q + 3'd1;
      if (o_done) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      step_q <= '0;
      run_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      step_q <= step_d;
      run_q  <= run_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_conv_scheduler.sv
// +----------------------------------------------------------------------+
// | bcd_conv_scheduler : round-robin sharing of one serial BCD converter |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_conv_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int REFRESH_DIV = 14000000,
  parameter int CNT_W       = 32
) (
  input  logic               iCLK_50,
  input  logic               iRST_n,
  input  logic               iEN_AUTO,
  input  logic [NCH-1:0]     iREQ,
  input  logic [NCH*8-1:0]   iHEX,
  output logic [NCH-1:0]     oGNT,
  output logic               oBUSY,
  output logic [NCH*12-1:0]  oBCD,
  output logic [NCH-1:0]     oVALID,
  output logic               oDONE,
  output logic [2:0]         oDONE_CH
);

  state_t              state_q, state_d;
  logic [NCH-1:0]      pend_q, pend_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [2:0]          win_q, win_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NCH*12-1:0]   bank_q, bank_d;
  logic [NCH-1:0]      valid_q, valid_d;
  logic                done_q, done_d;
  logic [2:0]          done_ch_q, done_ch_d;

  logic                w_tick;
  logic [NCH-1:0]      w_set, w_clr, w_gnt;
  logic [7:0]          w_pend_ext;
  logic [2:0]          w_win;
  logic                w_start, w_dd_done;
  logic [BIN_W-1:0]    w_hex_sel;
  logic [BCD_W-1:0]    w_dd_bcd;

  assign w_tick = iEN_AUTO && (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign w_set  = iREQ | {NCH{w_tick}};

  always_comb begin
    w_pend_ext           = '0;
    w_pend_ext[NCH-1:0]  = pend_q;
  end

  assign w_win     = rr_pick(w_pend_ext, ptr_q, NCH);
  assign w_hex_sel = iHEX[BIN_W*w_win +: BIN_W];

  always_comb begin
    if (!iEN_AUTO || w_tick) cnt_d = '0;
    else                     cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    bank_d    = bank_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    done_ch_d = done_ch_q;
    w_clr     = '0;
    w_gnt     = '0;
    w_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Incoming requests count immediately so LOAD follows the request cycle.
        if ((pend_q | w_set) != '0) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        w_gnt   = NCH'(1) << w_win;
        w_clr   = NCH'(1) << w_win;
        w_start = 1'b1;
        win_d   = w_win;
        ptr_d   = (w_win == 3'(NCH - 1)) ? 3'd0 : w_win + 3'd1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_dd_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        bank_d[BCD_W*win_q +: BCD_W] = w_dd_bcd;
        valid_d   = valid_q | (NCH'(1) << win_q);
        done_d    = 1'b1;
        done_ch_d = win_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set beats clear so a request arriving during LOAD re-queues the channel.
  assign pend_d = (pend_q & ~w_clr) | w_set;

  bcd_dd8_serial u_dd (
    .clk     (iCLK_50),
    .rst_n   (iRST_n),
    .i_start (w_start),
    .i_bin   (w_hex_sel),
    .o_bcd   (w_dd_bcd),
    .o_done  (w_dd_done)
  );

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      bank_q    <= '0;
      valid_q   <= '0;
      done_q    <= 1'b0;
      done_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
    end
  end

  assign oGNT     = w_gnt;
  assign oBUSY    = (state_q != ST_IDLE);
  assign oBCD     = bank_q;
  assign oVALID   = valid_q;
  assign oDONE    = done_q;
  assign oDONE_CH = done_ch_q;

endmodule

`default_nettype wire
